// File: rtl/regfile_sb_pkg.sv
// regfile_sb_pkg: shared sizing for the integer register file and its
// write-back scoreboard.
//   XLEN          register data width
//   REG_NUM       architectural register count, x0 included
//   REG_IDX_WIDTH register index width, log2(REG_NUM)
//   NUM_RD_PORTS  decode-side read ports (rs1, rs2)
package regfile_sb_pkg;

  localparam int XLEN          = 32;
  localparam int REG_NUM       = 32;
  localparam int REG_IDX_WIDTH = 5;
  localparam int NUM_RD_PORTS  = 2;

endpackage

// File: rtl/regfile_sb_board.sv
// regfile_sb_board: busy-bit scoreboard for in-flight rd writes.
//   clk, rst          clock, synchronous active-high reset
//   rs1_*/rs2_*       decode source indices and read enables
//   rd_idx, rd_en     destination of the decoding instruction
//   issue             decoding instruction leaves decode (before gating)
//   flush             squash every in-flight write
//   wb_en, wb_idx     write-back retiring a pending rd
//   hazard            decode must stall
//   busy              current busy vector
module regfile_sb_board
  import regfile_sb_pkg::*;
#(
  parameter int REG_NUM       = regfile_sb_pkg::REG_NUM,
  parameter int REG_IDX_WIDTH = regfile_sb_pkg::REG_IDX_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [REG_IDX_WIDTH-1:0] rs1_idx,
  input  logic                     rs1_en,
  input  logic [REG_IDX_WIDTH-1:0] rs2_idx,
  input  logic                     rs2_en,
  input  logic [REG_IDX_WIDTH-1:0] rd_idx,
  input  logic                     rd_en,
  input  logic                     issue,
  input  logic                     flush,
  input  logic                     wb_en,
  input  logic [REG_IDX_WIDTH-1:0] wb_idx,
  output logic                     hazard,
  output logic [REG_NUM-1:0]       busy
);

  logic [REG_NUM-1:0] busy_q, busy_nxt;
  logic               rs1_haz, rs2_haz, rd_haz;

  // A write-back landing this cycle resolves the dependency, since the
  // read port bypasses wb_data the same cycle.
  assign rs1_haz = rs1_en && (rs1_idx != '0) && busy_q[rs1_idx] &&
                   !(wb_en && (wb_idx == rs1_idx));
  assign rs2_haz = rs2_en && (rs2_idx != '0) && busy_q[rs2_idx] &&
                   !(wb_en && (wb_idx == rs2_idx));
  // Single busy bit per register: a second writer waits (WAW ordering).
  assign rd_haz  = rd_en  && (rd_idx  != '0) && busy_q[rd_idx]  &&
                   !(wb_en && (wb_idx == rd_idx));

  assign hazard = rs1_haz || rs2_haz || rd_haz;
  assign busy   = busy_q;

  always_comb begin
    busy_nxt = busy_q;
    if (wb_en)
      busy_nxt[wb_idx] = 1'b0;
    // Applied after the clear so that the newer writer owns the register.
    if (issue && !hazard && rd_en && (rd_idx != '0))
      busy_nxt[rd_idx] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)        busy_q <= '0;
    else if (flush) busy_q <= '0;
    else            busy_q <= busy_nxt;
  end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with write-through bypass plus the
// write-back scoreboard that stalls decode on pending operands or rd.
//   clk_i, rst_i              clock, synchronous active-high reset
//   dec_rs{1,2}_idx_i/_en_i   decode read requests
//   dec_rd_idx_i, dec_rd_en_i destination of the decoding instruction
//   dec_rs{1,2}_o             operands, combinational
//   issue_i, flush_i          decode leaves / pipeline flush
//   wb_en_i, wb_idx_i, wb_data_i  write-back port
//   hazard_o                  stall decode
//   busy_o                    scoreboard vector (debug/trace)
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int XLEN          = regfile_sb_pkg::XLEN,
  parameter int REG_NUM       = regfile_sb_pkg::REG_NUM,
  parameter int REG_IDX_WIDTH = regfile_sb_pkg::REG_IDX_WIDTH
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [REG_IDX_WIDTH-1:0] dec_rs1_idx_i,
  input  logic [REG_IDX_WIDTH-1:0] dec_rs2_idx_i,
  input  logic                     dec_rs1_en_i,
  input  logic                     dec_rs2_en_i,
  input  logic [REG_IDX_WIDTH-1:0] dec_rd_idx_i,
  input  logic                     dec_rd_en_i,
  output logic [XLEN-1:0]          dec_rs1_o,
  output logic [XLEN-1:0]          dec_rs2_o,
  input  logic                     issue_i,
  input  logic                     flush_i,
  input  logic                     wb_en_i,
  input  logic [REG_IDX_WIDTH-1:0] wb_idx_i,
  input  logic [XLEN-1:0]          wb_data_i,
  output logic                     hazard_o,
  output logic [REG_NUM-1:0]       busy_o
);

  logic [XLEN-1:0] regs [REG_NUM];

  logic [NUM_RD_PORTS-1:0][REG_IDX_WIDTH-1:0] rd_idx;
  logic [NUM_RD_PORTS-1:0][XLEN-1:0]          rd_data;

  // x0 is never written, so it holds its reset value of zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
    end else if (wb_en_i && (wb_idx_i != '0)) begin
      regs[wb_idx_i] <= wb_data_i;
    end
  end

  assign rd_idx[0] = dec_rs1_idx_i;
  assign rd_idx[1] = dec_rs2_idx_i;

  // Read ports ignore their enables; the enables only gate hazards.
  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
    always_comb begin
      if (rd_idx[p] == '0)
        rd_data[p] = '0;
      else if (wb_en_i && (wb_idx_i == rd_idx[p]))
        rd_data[p] = wb_data_i;
      else
        rd_data[p] = regs[rd_idx[p]];
    end
  end

  assign dec_rs1_o = rd_data[0];
  assign dec_rs2_o = rd_data[1];

  regfile_sb_board #(
    .REG_NUM       (REG_NUM),
    .REG_IDX_WIDTH (REG_IDX_WIDTH)
  ) u_board (
    .clk     (clk_i),
    .rst     (rst_i),
    .rs1_idx (dec_rs1_idx_i),
    .rs1_en  (dec_rs1_en_i),
    .rs2_idx (dec_rs2_idx_i),
    .rs2_en  (dec_rs2_en_i),
    .rd_idx  (dec_rd_idx_i),
    .rd_en   (dec_rd_en_i),
    .issue   (issue_i),
    .flush   (flush_i),
    .wb_en   (wb_en_i),
    .wb_idx  (wb_idx_i),
    .hazard  (hazard_o),
    .busy    (busy_o)
  );

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Integer register file and write-back scoreboard; the responder to the decode stage's register-read requests.
- Takes rs1/rs2 indices and enables from decode and returns operand values in the same cycle.
- Accepts the write-back of rd from the end of the pipe.
- Tracks in-flight rd writes and raises a hazard stall toward the pipeline control.

Parameters:
XLEN, 32, register data width
REG_NUM, 32, number of architectural registers (x0 included)
REG_IDX_WIDTH, 5, register index width, log2(REG_NUM)

Ports:
clk_i  input  1  core clock
rst_i  input  1  synchronous active-high reset
dec_rs1_idx_i  input  REG_IDX_WIDTH  rs1 index from decode
dec_rs2_idx_i  input  REG_IDX_WIDTH  rs2 index from decode
dec_rs1_en_i  input  1  decode reads rs1
dec_rs2_en_i  input  1  decode reads rs2
dec_rd_idx_i  input  REG_IDX_WIDTH  rd index of the decoding instruction
dec_rd_en_i  input  1  decoding instruction writes rd
dec_rs1_o  output  XLEN  rs1 operand value to decode
dec_rs2_o  output  XLEN  rs2 operand value to decode
issue_i  input  1  decoding instruction leaves decode this cycle (before hazard gating)
flush_i  input  1  pipeline flush; squashes all in-flight writes
wb_en_i  input  1  write-back valid
wb_idx_i  input  REG_IDX_WIDTH  write-back rd index
wb_data_i  input  XLEN  write-back data
hazard_o  output  1  stall decode; operand or rd still pending
busy_o  output  REG_NUM  scoreboard bit vector, for debug/trace

Behaviour:
Reset:
- Synchronous, active-high, on rising clk_i when rst_i=1.
- All registers are cleared to 0 and all busy bits are cleared.
- Outputs during and after reset: hazard_o=0 (combinational from busy=0), busy_o=0.

Register x0:
- Reads of x0 always return 0.
- Writes to x0 are discarded.
- busy[0] is never set.

Read ports:
- Combinational, zero latency: dec_rsN_o = regs[idx].
- Write-through bypass: if wb_en_i=1, wb_idx_i==idx and idx!=0, then dec_rsN_o = wb_data_i in the same cycle.
- With dec_rsN_en_i=0, dec_rsN_o is still driven with the array value; the enable gates only hazard detection.

Write port:
- When wb_en_i=1 and wb_idx_i!=0, regs[wb_idx_i] <= wb_data_i on the next rising edge.

Scoreboard:
- busy[i]=1 means a write to xi has issued but not yet written back.
- Set: issue_i=1, hazard_o=0, dec_rd_en_i=1, dec_rd_idx_i!=0 sets busy[dec_rd_idx_i] on the next edge.
- Clear: wb_en_i=1 clears busy[wb_idx_i] on the next edge.
- Same index set and cleared in one cycle: set wins (the newer writer owns the register).
- flush_i=1 clears all busy bits on the next edge and overrides any set that cycle. Write-back on a flush cycle is still committed to the array.
- rst_i has priority over flush_i, which has priority over set/clear.

Hazard (combinational):
- Per source: rsN_haz = dec_rsN_en_i & busy[idx] & ~(wb_en_i & wb_idx_i==idx).
- rd_haz = dec_rd_en_i & busy[dec_rd_idx_i] & ~(wb_en_i & wb_idx_i==dec_rd_idx_i). This enforces WAW ordering with a single busy bit per register.
- hazard_o = rs1_haz | rs2_haz | rd_haz. Index 0 never hazards.
- issue_i while hazard_o=1 is ignored: no busy update. Pipeline control must also hold decode.

Pipeline assumptions:
- At most one issue and one write-back per cycle.
- Write-backs to registers not marked busy are legal, e.g. after a flush. They write the array and leave busy unchanged (stays 0).

Decomposition:
- Shared defines (existing defines.v): XLEN, REG_IDX_WIDTH, REG_NUM.
- One natural sub-module, regfile_sb_board: the busy-vector state plus set/clear/flush logic and hazard compare, taking indices and enables as inputs.
- The storage array and bypass mux stay in the top module.

Test Plan:
1. Reset, then read x5 and x0 → dec_rs1_o=0, dec_rs2_o=0, hazard_o=0, busy_o=0.
2. Write-back wb_idx=3, data=0xDEADBEEF; read x3 in the same cycle → 0xDEADBEEF via bypass. Read again next cycle → 0xDEADBEEF from the array. Write-back to x0 with 0x1234 → x0 still reads 0.
3. Issue rd=7 (rd_en=1). Next cycle decode rs1=7, rs1_en=1 → hazard_o=1 and the issue is ignored. Then wb idx=7 data=0x55 → hazard_o=0 in that cycle, dec_rs1_o=0x55, busy[7] clears after the edge.
4. busy[9]=1; in one cycle wb_idx=9 and issue rd=9 (rs not busy) → hazard_o=0 and busy[9]=1 after the edge (set wins). A rs2=9 read with rs2_en=0 → no hazard.
5. busy[4]=busy[6]=1; flush_i=1 together with issue rd=8 → busy_o=0 after the edge. A later wb idx=4 data=0x77 writes the array and busy stays 0.
6. Busy bits set and x10=0xA; assert rst_i for one cycle mid-operation → busy_o=0, x10 reads 0, hazard_o=0.
